spi_sclk_gen: RTL and testbench

- Parametrised SPI serial-clock generator; successor to the fixed divide-by-32 free-running divider.
- Produces a burst of exactly 2*num_bits SCLK edges at a runtime-selectable rate, with CPOL/CPHA mode support.
- Emits single-cycle sample/shift strobes aligned to SCLK edges, plus busy/done handshake signals.
- Sits between the SPI master control FSM and the shift register and pad logic.

---
 rtl/spi_sclk_gen.sv | 209 ++++++++++++++++++++
 tb/tb_spi_sclk_gen.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen -- SPI serial-clock burst generator.
//
// Generates a burst of exactly 2*num_bits SCLK edges. Each half-period lasts
// div+1 clk cycles. The block supports all four CPOL/CPHA modes and emits
// single-cycle sample/shift strobes that line up with the SCLK edges. A
// busy/done handshake connects it to the SPI master control FSM.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous reset, active low
//   start          one-cycle burst request, honoured only while idle
//   abort          ends a running burst at once, with no done pulse
//   div            half-period minus one, in clk cycles
//   num_bits       number of SCLK periods in the burst (0 = no edges)
//   cpol           SCLK idle level
//   cpha           0: sample on the leading edge, 1: sample on the trailing edge
//   sclk           registered serial clock
//   sample_strobe  one-cycle MISO sample pulse
//   shift_strobe   one-cycle MOSI update pulse
//   busy           high while a burst is in progress
//   done           one-cycle pulse when a burst completes normally
//
// Every output comes straight from a register. No combinational path runs
// from any input to any output.

`timescale 1ns/1ps

module spi_sclk_gen #(
    parameter int unsigned DIV_WIDTH = 8,
    parameter int unsigned CNT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [CNT_WIDTH-1:0] num_bits,
    input  logic                 cpol,
    input  logic                 cpha,
    output logic                 sclk,
    output logic                 sample_strobe,
    output logic                 shift_strobe,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

    localparam logic [DIV_WIDTH-1:0] HC_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH:0]   EC_ONE = {{CNT_WIDTH{1'b0}}, 1'b1};

    logic [1:0]           state_q,  state_d;
    logic [DIV_WIDTH-1:0] hc_q,     hc_d;      // half-period cycle counter
    logic [CNT_WIDTH:0]   ec_q,     ec_d;      // SCLK edges produced so far
    logic [DIV_WIDTH-1:0] div_q,    div_d;
    logic [CNT_WIDTH-1:0] nbits_q,  nbits_d;
    logic                 cpol_q,   cpol_d;
    logic                 cpha_q,   cpha_d;
    logic                 sclk_q,   sclk_d;
    logic                 sample_q, sample_d;
    logic                 shift_q,  shift_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;

    logic [CNT_WIDTH:0]   ec_inc;
    logic [CNT_WIDTH:0]   last_edge;
    logic                 hp_end;
    logic                 lead_edge;

    always_comb begin
        // NOTE: every variable gets a default value first. Any path that skips an assignment then holds the value, so no latch is inferred.
        state_d   = state_q;
        hc_d      = hc_q;
        ec_d      = ec_q;
        div_d     = div_q;
        nbits_d   = nbits_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        sclk_d    = sclk_q;
        busy_d    = busy_q;
        sample_d  = 1'b0;
        shift_d   = 1'b0;
        done_d    = 1'b0;

        ec_inc    = ec_q + EC_ONE;
        // A burst of N bits ends on edge 2N. That count is even, so SCLK
        // returns to its idle level by itself.
        last_edge = {nbits_q, 1'b0};
        hp_end    = (hc_q == div_q);
        // Odd-numbered edges are the leading edges of each SCLK period.
        lead_edge = ec_inc[0];

        case (state_q)
            ST_IDLE: begin
                cpol_d = cpol;
                sclk_d = cpol;
                busy_d = 1'b0;
                // start wins over abort here: abort means nothing while idle.
                if (start) begin
                    div_d   = div;
                    nbits_d = num_bits;
                    cpha_d  = cpha;
                    hc_d    = '0;
                    ec_d    = '0;
                    busy_d  = 1'b1;
                    state_d = (num_bits == '0) ? ST_GUARD : ST_RUN;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    // abort takes priority even over a terminal edge in the same cycle.
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    sclk_d  = cpol_q;
                    hc_d    = '0;
                    ec_d    = '0;
                end else if (hp_end) begin
                    hc_d   = '0;
                    ec_d   = ec_inc;
                    sclk_d = ~sclk_q;
                    if (cpha_q) begin
                        shift_d  = lead_edge;
                        sample_d = ~lead_edge;
                    end else begin
                        sample_d = lead_edge;
                        // No MOSI update after the final trailing edge:
                        // there is no further bit to present.
                        shift_d  = ~lead_edge && (ec_inc != last_edge);
                    end
                    if (ec_inc == last_edge) begin
                        state_d = ST_GUARD;
                    end
                end else begin
                    hc_d = hc_q + HC_ONE;
                end
            end

            ST_GUARD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    sclk_d  = cpol_q;
                    hc_d    = '0;
                    ec_d    = '0;
                end else if (hp_end) begin
                    // One idle half-period after the last edge holds off
                    // the slave-select release.
                    hc_d    = '0;
                    ec_d    = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    hc_d = hc_q + HC_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                sclk_d  = cpol_q;
                hc_d    = '0;
                ec_d    = '0;
            end
        endcase
    end

    // NOTE: every register, including the latched configuration, is reset. This keeps the first burst after reset deterministic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            hc_q     <= '0;
            ec_q     <= '0;
            div_q    <= '0;
            nbits_q  <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            sclk_q   <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all registers update together from the values of the previous cycle.
            state_q  <= state_d;
            hc_q     <= hc_d;
            ec_q     <= ec_d;
            div_q    <= div_d;
            nbits_q  <= nbits_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            sclk_q   <= sclk_d;
            sample_q <= sample_d;
            shift_q  <= shift_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sclk          = sclk_q;
    assign sample_strobe = sample_q;
    assign shift_strobe  = shift_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Self-checking bench for spi_sclk_gen.
//
// The reference model works from the time offset t, in clk cycles, since
// busy rose. Edge k appears at t = k*(div+1). The burst ends with done at
// t = (2N+1)*(div+1). A table of directed bursts holds hand-computed done
// latencies and strobe counts. Hand-written sequences cover abort, abort
// priority, and asynchronous reset.

`timescale 1ns/1ps

module tb_spi_sclk_gen;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic       abort    = 1'b0;
    logic [7:0] div      = 8'd0;
    logic [5:0] num_bits = 6'd0;
    logic       cpol     = 1'b0;
    logic       cpha     = 1'b0;
    logic       sclk;
    logic       sample_strobe;
    logic       shift_strobe;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    spi_sclk_gen #(.DIV_WIDTH(8), .CNT_WIDTH(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .div           (div),
        .num_bits      (num_bits),
        .cpol          (cpol),
        .cpha          (cpha),
        .sclk          (sclk),
        .sample_strobe (sample_strobe),
        .shift_strobe  (shift_strobe),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] div;
        logic [5:0] n;
        logic       cpol;
        logic       cpha;
    } cfg_t;

    typedef struct {
        cfg_t cfg;
        bit   chain;        // start in the done cycle of the previous burst
        bit   start_abort;  // assert abort together with start (start must win)
        int   exp_done;
        int   exp_samp;
        int   exp_shift;
    } vec_t;

    function automatic cfg_t mk_cfg(input int d, input int n, input int p, input int h);
        cfg_t c;
        c.div  = 8'(d);
        c.n    = 6'(n);
        c.cpol = 1'(p);
        c.cpha = 1'(h);
        return c;
    endfunction

    function automatic vec_t mk_vec(input cfg_t c, input bit ch, input bit sa,
                                    input int ed, input int es, input int eh);
        vec_t v;
        v.cfg = c; v.chain = ch; v.start_abort = sa;
        v.exp_done = ed; v.exp_samp = es; v.exp_shift = eh;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: expected outputs t cycles after busy rose.
    task automatic check_cycle(input cfg_t c, input int t);
        int  d_len, n, t_end, k;
        bit  e_busy, e_done, e_sclk, e_samp, e_shift, edge_now, odd;
        d_len = int'(c.div) + 1;
        n     = int'(c.n);
        t_end = (2 * n + 1) * d_len;
        e_samp = 1'b0; e_shift = 1'b0;
        if (t < t_end) begin
            e_busy   = 1'b1;
            e_done   = 1'b0;
            k        = t / d_len;
            e_sclk   = c.cpol ^ k[0];
            edge_now = (t > 0) && (t % d_len == 0);
            odd      = k[0];
            if (edge_now) begin
                e_samp  = c.cpha ? !odd : odd;
                e_shift = c.cpha ? odd : (!odd && (k != 2 * n));
            end
        end else begin
            e_busy = 1'b0;
            e_done = (t == t_end);
            e_sclk = c.cpol;
        end
        check($sformatf("busy@t%0d", t),   int'(busy),          int'(e_busy));
        check($sformatf("done@t%0d", t),   int'(done),          int'(e_done));
        check($sformatf("sclk@t%0d", t),   int'(sclk),          int'(e_sclk));
        check($sformatf("sample@t%0d", t), int'(sample_strobe), int'(e_samp));
        check($sformatf("shift@t%0d", t),  int'(shift_strobe),  int'(e_shift));
    endtask

    // One idle cycle: sclk must follow the cpol input with one cycle of delay.
    task automatic idle_step(input bit cp, input bit ab);
        cpol  = cp;
        abort = ab;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_sclk", int'(sclk), int'(cp));
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
    endtask

    // Runs one full burst, checking every cycle against the model. The task
    // returns at the negedge of the done cycle, so a caller can chain a new
    // start immediately.
    task automatic run_burst(input cfg_t c, input bit scramble, input bit sa,
                             output int done_lat, output int n_samp, output int n_shift);
        int t_end;
        t_end    = (2 * int'(c.n) + 1) * (int'(c.div) + 1);
        div      = c.div; num_bits = c.n; cpol = c.cpol; cpha = c.cpha;
        start    = 1'b1;  abort    = sa;
        @(posedge clk); #1;
        start    = 1'b0;  abort    = 1'b0;
        done_lat = -1; n_samp = 0; n_shift = 0;
        for (int t = 0; t <= t_end; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
            end
            if (scramble && t < t_end) begin
                // Config and start changes while busy must not disturb the burst.
                div      = 8'($urandom);
                num_bits = 6'($urandom);
                cpol     = 1'($urandom);
                cpha     = 1'($urandom);
                start    = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            check_cycle(c, t);
            if (done) done_lat = t;
            n_samp  += int'(sample_strobe);
            n_shift += int'(shift_strobe);
        end
    endtask

    // Burst with abort asserted during cycle abort_t. An optional ignored start goes in at start_t.
    task automatic run_abort(input cfg_t c, input int abort_t, input int start_t, input string tag);
        div   = c.div; num_bits = c.n; cpol = c.cpol; cpha = c.cpha;
        start = 1'b1;  abort    = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t <= abort_t + 6; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
            end
            start = (t == start_t);
            abort = (t == abort_t);
            @(negedge clk);
            if (t <= abort_t) begin
                check_cycle(c, t);
            end else begin
                check({tag, "_busy"},   int'(busy),          0);
                check({tag, "_done"},   int'(done),          0);
                check({tag, "_sclk"},   int'(sclk),          int'(c.cpol));
                check({tag, "_sample"}, int'(sample_strobe), 0);
                check({tag, "_shift"},  int'(shift_strobe),  0);
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        cfg_t c;
        int   dl, ns, nh, d, n;

        vecs[0] = mk_vec(mk_cfg(3, 8, 0, 0), 1'b0, 1'b0, 68, 8, 7);
        vecs[1] = mk_vec(mk_cfg(1, 4, 1, 1), 1'b0, 1'b0, 18, 4, 4);
        vecs[2] = mk_vec(mk_cfg(0, 1, 0, 0), 1'b0, 1'b0,  3, 1, 0);
        vecs[3] = mk_vec(mk_cfg(0, 1, 0, 0), 1'b1, 1'b0,  3, 1, 0);
        vecs[4] = mk_vec(mk_cfg(5, 0, 0, 0), 1'b0, 1'b0,  6, 0, 0);
        vecs[5] = mk_vec(mk_cfg(2, 3, 1, 0), 1'b0, 1'b0, 21, 3, 2);
        vecs[6] = mk_vec(mk_cfg(0, 2, 0, 1), 1'b0, 1'b1,  5, 2, 2);

        // Asynchronous reset at power-up.
        #1 reset = 1'b0;
        #2;
        check("rst_sclk",   int'(sclk),          0);
        check("rst_busy",   int'(busy),          0);
        check("rst_done",   int'(done),          0);
        check("rst_sample", int'(sample_strobe), 0);
        check("rst_shift",  int'(shift_strobe),  0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_busy", int'(busy), 0);
        reset = 1'b1;
        @(negedge clk);

        // Directed table. Mode 3 idles high before its burst begins.
        for (int i = 0; i < 7; i++) begin
            if (!vecs[i].chain) begin
                idle_step(vecs[i].cfg.cpol, 1'b1);   // abort while idle is ignored
                idle_step(vecs[i].cfg.cpol, 1'b0);
            end
            run_burst(vecs[i].cfg, 1'b0, vecs[i].start_abort, dl, ns, nh);
            check($sformatf("vec%0d_done_lat", i), dl, vecs[i].exp_done);
            check($sformatf("vec%0d_samples", i),  ns, vecs[i].exp_samp);
            check($sformatf("vec%0d_shifts", i),   nh, vecs[i].exp_shift);
        end

        // Abort one cycle after the 5th edge, with an ignored start mid-burst.
        idle_step(1'b1, 1'b0);
        run_abort(mk_cfg(2, 8, 1, 0), 16, 5, "abort_run");
        // An abort in the cycle that would produce the terminal edge wins.
        idle_step(1'b0, 1'b0);
        run_abort(mk_cfg(1, 2, 0, 1), 7, -1, "abort_last");
        // Abort during the guard half-period: no done pulse afterwards.
        idle_step(1'b1, 1'b0);
        run_abort(mk_cfg(3, 1, 1, 0), 9, 2, "abort_guard");

        // Asynchronous reset at edge 3, with config changed while busy.
        idle_step(1'b0, 1'b0);
        c     = mk_cfg(1, 6, 0, 0);
        div   = c.div; num_bits = c.n; cpol = c.cpol; cpha = c.cpha;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t <= 6; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            check_cycle(c, t);
        end
        div = 8'd0; num_bits = 6'd2; cpol = 1'b1; cpha = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("midrst_sclk",   int'(sclk),          0);
        check("midrst_busy",   int'(busy),          0);
        check("midrst_done",   int'(done),          0);
        check("midrst_sample", int'(sample_strobe), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("postrst_busy", int'(busy), 0);
        run_burst(mk_cfg(0, 2, 1, 1), 1'b0, 1'b0, dl, ns, nh);
        check("postrst_done_lat", dl, 5);
        check("postrst_samples",  ns, 2);
        check("postrst_shifts",   nh, 2);

        // Randomised bursts with config scrambling and optional back-to-back starts.
        for (int i = 0; i < 25; i++) begin
            d = int'($urandom_range(0, 6));
            n = int'($urandom_range(0, 10));
            c = mk_cfg(d, n, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) idle_step(c.cpol, 1'($urandom));
            run_burst(c, 1'b1, 1'b0, dl, ns, nh);
            check("rand_done_lat", dl, (2 * n + 1) * (d + 1));
            check("rand_samples",  ns, n);
            check("rand_shifts",   nh, c.cpha ? n : ((n > 0) ? n - 1 : 0));
        end

        // Largest divisor: half-period of 256 cycles.
        idle_step(1'b0, 1'b0);
        run_burst(mk_cfg(255, 1, 0, 0), 1'b0, 1'b0, dl, ns, nh);
        check("maxdiv_done_lat", dl, 768);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
